ws2811_rx: RTL and testbench
============================

WS2811_RX -- requirements
Module: ws2811_rx

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8, number of pixels captured per frame.
REQ-002 SHALL have parameter T_BIT_THRESH, default 60, high-pulse cycles at or above which the bit is 1.
REQ-003 SHALL have parameter T_HIGH_MIN, default 15, shortest legal high pulse in cycles.
REQ-004 SHALL have parameter T_HIGH_MAX, default 150, longest legal high pulse in cycles.
REQ-005 SHALL have parameter T_RESET, default 5000, low cycles that end a frame (50 us at 100 MHz).
REQ-006 SHALL have port clk  input  1  single system clock, rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port DI  input  1  asynchronous serial data in, WS2811 one-wire format.
REQ-009 SHALL have port address  output  $clog2(NUM_LEDS)  index of the pixel in red_out/green_out/blue_out.
REQ-010 SHALL have ports red_out, green_out, blue_out  output  8 each  decoded pixel colour.
REQ-011 SHALL have port valid  output  1  one-cycle strobe: pixel outputs hold a new pixel.
REQ-012 SHALL have port frame_done  output  1  one-cycle strobe: reset gap detected after at least one bit.
REQ-013 SHALL have port error  output  1  one-cycle strobe: illegal pulse or partial pixel.
REQ-014 SHALL have port DO  output  1  forwarded data for downstream chain.

Function
REQ-015 DI SHALL pass through a two-flop synchronizer; all decoding uses the synchronized signal (sdi).
REQ-016 FSM states SHALL be SYNC, IDLE, HIGH, LOW.
REQ-017 SYNC: count consecutive low sdi cycles; any high clears the count; count reaching T_RESET -> IDLE, no strobe.
REQ-018 IDLE: sdi rising -> HIGH with pulse counter = 1.
REQ-019 HIGH: counter increments per high cycle; counter exceeding T_HIGH_MAX -> error strobe, go SYNC.
REQ-020 HIGH, sdi falls: counter < T_HIGH_MIN -> error strobe, go SYNC; else shift bit (counter >= T_BIT_THRESH) into 24-bit shift register MSB-first, go LOW, counter = 1.
REQ-021 Bit order SHALL be G[7:0], R[7:0], B[7:0], MSB first, matching the team's ws2811 driver.
REQ-022 On the 24th bit: register outputs, valid high exactly one cycle on the following clock, address = pixel index, index increments, bit count clears.
REQ-023 Latency from DI falling edge of bit 24 to valid SHALL be 3 clk cycles.
REQ-024 LOW: sdi rising -> HIGH; low count reaching T_RESET -> frame_done strobe, index and bit count clear, go IDLE.
REQ-025 Frame end with nonzero bit count SHALL assert error and frame_done in the same cycle; partial pixel discarded.
REQ-026 Pixels after index NUM_LEDS-1 SHALL NOT assert valid; after NUM_LEDS pixels, DO = sdi until frame end, else DO = 0.
REQ-027 Pulse and gap counters SHALL saturate, never wrap.
REQ-028 On error, index and bit count SHALL clear; outputs hold their last values.

Reset
REQ-029 Reset SHALL force state SYNC, counters/index/shift register 0, synchronizer flops 0.
REQ-030 Reset values: address 0, red_out/green_out/blue_out 0, valid 0, frame_done 0, error 0, DO 0.
REQ-031 Reset mid-frame SHALL drop the partial pixel, issue no strobe, and require a full T_RESET low gap before decoding again.

Structure
REQ-032 Package ws2811_pkg SHALL hold the FSM state type and default timing constants, shared with the ws2811 driver.
REQ-033 Synchronizer SHALL be sub-module ws2811_rx_sync (2-flop, reset to 0); the rest stays in ws2811_rx.

Verification
REQ-034 Loopback: ws2811 driver (NUM_LEDS=8, red FF, green AA, blue 00) -> DI; 8 valid strobes, addresses 0..7, each red_out FF, green_out AA, blue_out 00; then frame_done.
REQ-035 Single pulse: a 10-cycle high pulse after a gap -> error one cycle, state SYNC, no valid.
REQ-036 Overlength: DI held high 200 cycles -> error when count passes 150, no valid.
REQ-037 Partial pixel: 12 bits then 6000 low cycles -> frame_done and error in the same cycle, no valid.
REQ-038 Overflow: 10 pixels into NUM_LEDS=8 -> 8 valid strobes; DO mirrors sdi during pixels 9-10; DO 0 after frame_done.
REQ-039 Reset during bit 15 of pixel 2, then a new frame without a 5000-cycle gap -> no valid until a full gap precedes the next frame.

Source files
------------

// File: rtl/ws2811_pkg.sv
// ws2811_pkg: FSM state type and default timing shared by the ws2811 driver and receiver
package ws2811_pkg;
    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} rx_state_t;
    localparam int WS_NUM_LEDS = 8;
    localparam int WS_T_BIT_THRESH = 60;
    localparam int WS_T_HIGH_MIN = 15;
    localparam int WS_T_HIGH_MAX = 150;
    localparam int WS_T_RESET = 5000;
endpackage

// File: rtl/ws2811_rx_sync.sv
// ws2811_rx_sync: two-flop synchronizer for the asynchronous one-wire input
module ws2811_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) {q, meta} <= 2'b00;
        else {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/ws2811_rx.sv
// ws2811_rx: WS2811 one-wire pixel decoder with downstream forwarding
module ws2811_rx import ws2811_pkg::*; #(
    parameter int NUM_LEDS = WS_NUM_LEDS,
    parameter int T_BIT_THRESH = WS_T_BIT_THRESH,
    parameter int T_HIGH_MIN = WS_T_HIGH_MIN,
    parameter int T_HIGH_MAX = WS_T_HIGH_MAX,
    parameter int T_RESET = WS_T_RESET
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        DI,
    output logic [$clog2(NUM_LEDS)-1:0] address,
    output logic [7:0]                  red_out,
    output logic [7:0]                  green_out,
    output logic [7:0]                  blue_out,
    output logic                        valid,
    output logic                        frame_done,
    output logic                        error,
    output logic                        DO
);
    localparam int AW = $clog2(NUM_LEDS);
    localparam int IW = $clog2(NUM_LEDS + 1);
    localparam int CMAX = T_RESET > T_HIGH_MAX + 1 ? T_RESET : T_HIGH_MAX + 1;
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] C_ONE = CW'(1);
    localparam logic [CW-1:0] C_THRESH = CW'(T_BIT_THRESH);
    localparam logic [CW-1:0] C_HMIN = CW'(T_HIGH_MIN);
    localparam logic [CW-1:0] C_HMAX = CW'(T_HIGH_MAX);
    localparam logic [CW-1:0] C_RESET = CW'(T_RESET);
    localparam logic [IW-1:0] I_END = IW'(NUM_LEDS);
    rx_state_t state, state_n;
    logic sdi, pix, done, err, live;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [4:0] bits, bits_n;
    logic [IW-1:0] idx, idx_n;
    logic [22:0] shreg, shreg_n;
    logic [23:0] word;
    ws2811_rx_sync u_sync (.clk(clk), .reset(reset), .d(DI), .q(sdi));
    assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
    assign word = {shreg, cnt >= C_THRESH};
    assign live = idx != I_END;
    // idx parks at NUM_LEDS once the local pixels are taken; the rest of the frame is forwarded
    assign DO = sdi && !live;
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        bits_n = bits;
        idx_n = idx;
        shreg_n = shreg;
        pix = 1'b0;
        done = 1'b0;
        err = 1'b0;
        case (state)
            SYNC: begin
                cnt_n = sdi ? '0 : cnt_inc;
                if (!sdi && cnt_inc >= C_RESET) begin
                    state_n = IDLE;
                    cnt_n = '0;
                end
            end
            IDLE: if (sdi) begin
                state_n = HIGH;
                cnt_n = C_ONE;
            end
            HIGH: if (cnt > C_HMAX || (!sdi && cnt < C_HMIN)) begin
                err = 1'b1;
                state_n = SYNC;
                cnt_n = '0;
                bits_n = '0;
                idx_n = '0;
            end else if (sdi) cnt_n = cnt_inc;
            else begin
                state_n = LOW;
                cnt_n = C_ONE;
                shreg_n = word[22:0];
                pix = bits == 5'd23;
                bits_n = pix ? '0 : bits + 5'd1;
                idx_n = pix && live ? idx + 1'b1 : idx;
            end
            LOW: if (sdi) begin
                state_n = HIGH;
                cnt_n = C_ONE;
            end else if (cnt_inc >= C_RESET) begin
                done = 1'b1;
                err = bits != '0;
                state_n = IDLE;
                cnt_n = '0;
                bits_n = '0;
                idx_n = '0;
            end else cnt_n = cnt_inc;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SYNC;
            cnt <= '0;
            bits <= '0;
            idx <= '0;
            shreg <= '0;
            address <= '0;
            red_out <= '0;
            green_out <= '0;
            blue_out <= '0;
            valid <= 1'b0;
            frame_done <= 1'b0;
            error <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            bits <= bits_n;
            idx <= idx_n;
            shreg <= shreg_n;
            valid <= pix && live;
            frame_done <= done;
            error <= err;
            if (pix && live) begin
                address <= idx[AW-1:0];
                green_out <= word[23:16];
                red_out <= word[15:8];
                blue_out <= word[7:0];
            end
        end
    end
endmodule

// File: tb/tb_ws2811_rx.sv
// tb_ws2811_rx: randomized one-wire frames checked against an event-level pixel model
module tb_ws2811_rx;
    import ws2811_pkg::*;
    localparam int N = WS_NUM_LEDS;
    localparam int TR = WS_T_RESET;
    localparam int THMAX = WS_T_HIGH_MAX;
    typedef struct packed {int cyc; logic [2:0] addr; logic [7:0] r; logic [7:0] g; logic [7:0] b;} pix_t;
    typedef struct packed {int lo; int hi;} win_t;
    logic clk = 1'b0, reset = 1'b1, DI = 1'b0;
    logic [2:0] address;
    logic [7:0] red_out, green_out, blue_out;
    logic valid, frame_done, error, DO;
    int cyc = 0, total = 0, bad = 0, last_fall = 0, do_bad = 0, do_hi = 0;
    logic d1 = 1'b0, d2 = 1'b0, mirror = 1'b0;
    pix_t got_v[$], exp_v[$];
    int got_f[$], exp_f[$], got_e[$];
    win_t exp_e[$];

    ws2811_rx #(.NUM_LEDS(N), .T_BIT_THRESH(WS_T_BIT_THRESH), .T_HIGH_MIN(WS_T_HIGH_MIN),
                .T_HIGH_MAX(THMAX), .T_RESET(TR)) dut (
        .clk(clk), .reset(reset), .DI(DI), .address(address), .red_out(red_out),
        .green_out(green_out), .blue_out(blue_out), .valid(valid), .frame_done(frame_done),
        .error(error), .DO(DO));

    always #5 clk = ~clk;

    // d2 is DI as seen after two clock edges, i.e. the decoder's view of the line
    always @(posedge clk) begin
        cyc <= cyc + 1;
        d1 <= DI;
        d2 <= d1;
    end

    always @(negedge clk) begin
        if (valid) got_v.push_back('{cyc, address, red_out, green_out, blue_out});
        if (frame_done) got_f.push_back(cyc);
        if (error) got_e.push_back(cyc);
        if (DO !== (mirror & d2)) do_bad++;
        if (DO) do_hi++;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        DI = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        int hi;
        hi = b ? int'($urandom_range(75, 60)) :
             ($urandom_range(7, 0) == 0 ? 59 : int'($urandom_range(30, 15)));
        drive(1'b1, hi);
        last_fall = cyc;
        drive(1'b0, int'($urandom_range(10, 2)));
    endtask

    task automatic send_pixel(input logic [23:0] w, input int idx, input bit expect_v);
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
        if (expect_v && idx < N) exp_v.push_back('{last_fall + 3, idx[2:0], w[15:8], w[23:16], w[7:0]});
    endtask

    task automatic gap(input int n, input bit expect_f);
        if (expect_f) exp_f.push_back(last_fall + TR + 2);
        drive(1'b0, n);
    endtask

    task automatic compare(input string name);
        repeat (4) @(negedge clk);
        check({name, " valid_count"}, got_v.size(), exp_v.size());
        foreach (got_v[i]) if (i < exp_v.size()) begin
            check({name, " valid_cycle"}, got_v[i].cyc, exp_v[i].cyc);
            check({name, " pixel"}, {got_v[i].addr, got_v[i].r, got_v[i].g, got_v[i].b},
                  {exp_v[i].addr, exp_v[i].r, exp_v[i].g, exp_v[i].b});
        end
        check({name, " frame_done_count"}, got_f.size(), exp_f.size());
        foreach (got_f[i]) if (i < exp_f.size()) check({name, " frame_done_cycle"}, got_f[i], exp_f[i]);
        check({name, " error_count"}, got_e.size(), exp_e.size());
        foreach (got_e[i]) if (i < exp_e.size())
            check($sformatf("%s error_in_window@%0d", name, got_e[i]),
                  longint'(got_e[i] >= exp_e[i].lo && got_e[i] <= exp_e[i].hi), 1);
        got_v.delete(); exp_v.delete(); got_f.delete(); exp_f.delete(); got_e.delete(); exp_e.delete();
    endtask

    initial begin
        int t;
        logic [23:0] w;
        repeat (3) @(negedge clk);
        check("rst address", address, 0);
        check("rst red_out", red_out, 0);
        check("rst green_out", green_out, 0);
        check("rst blue_out", blue_out, 0);
        check("rst valid", valid, 0);
        check("rst frame_done", frame_done, 0);
        check("rst error", error, 0);
        check("rst DO", DO, 0);
        reset = 1'b0;
        drive(1'b0, TR + 100);
        for (int p = 0; p < N; p++) send_pixel({8'hAA, 8'hFF, 8'h00}, p, 1'b1);
        gap(TR + 100, 1'b1);
        compare("loopback");
        drive(1'b1, 10);
        last_fall = cyc;
        exp_e.push_back('{last_fall + 3, last_fall + 3});
        drive(1'b0, 20);
        send_pixel(24'($urandom), 0, 1'b0);
        gap(TR + 100, 1'b0);
        compare("short_pulse");
        t = cyc;
        exp_e.push_back('{t + THMAX + 1, t + THMAX + 6});
        drive(1'b1, 200);
        drive(1'b0, TR + 100);
        compare("overlength");
        for (int i = 0; i < 12; i++) send_bit(1'($urandom_range(1, 0)));
        exp_e.push_back('{last_fall + TR + 2, last_fall + TR + 2});
        gap(6000, 1'b1);
        compare("partial");
        do_hi = 0;
        for (int p = 0; p < N + 2; p++) begin
            if (p == N) mirror = 1'b1;
            send_pixel(24'($urandom), p, 1'b1);
        end
        gap(TR + 100, 1'b1);
        mirror = 1'b0;
        compare("overflow");
        check("overflow DO_mirror_errors", do_bad, 0);
        check("overflow DO_forwarded", longint'(do_hi > 0), 1);
        send_pixel(24'($urandom), 0, 1'b1);
        w = 24'($urandom);
        for (int i = 23; i >= 10; i--) send_bit(w[i]);
        DI = 1'b1;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst red_out", red_out, 0);
        check("midrst green_out", green_out, 0);
        check("midrst address", address, 0);
        check("midrst error", error, 0);
        reset = 1'b0;
        drive(1'b0, 10);
        for (int p = 0; p < 2; p++) send_pixel(24'($urandom), p, 1'b0);
        gap(TR + 100, 1'b0);
        compare("reset_no_gap");
        for (int p = 0; p < 2; p++) send_pixel(24'($urandom), p, 1'b1);
        gap(TR + 100, 1'b1);
        compare("after_gap");
        check("final DO_mirror_errors", do_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
